ctu_sync_gen: RTL and testbench

//  Transmit end of the CTU clock-domain sync pulses: generates periodic global
//  ctu_jbus_tx/rx_sync and ctu_dram_tx/rx_sync pulses in the cmp domain from

---
 rtl/ctu_sync_gen.sv | 214 +++++++++++++++++++++
 tb/tb_ctu_sync_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ctu_sync_gen.sv
// ctu_sync_gen: transmit end of the CTU clock-domain sync pulses.
//
// Generates periodic jbus and dram tx/rx sync pulses in the cmp domain from
// programmable cmp:jbus and cmp:dram ratios. The pulses lead the aligned slow
// clock edge by JBUS_LEAD / DRAM_LEAD cmp cycles. This absorbs the downstream
// distribution flops and the cluster sync headers. sync_locked reports when
// the jbus pulse train has run for 8 full periods.
//
// Ports:
//   cmp_clk          in   cmp clock, the only clock
//   rst              in   synchronous active-high reset
//   cfg_ld           in   1-cycle pulse: load jbus_ratio / dram_ratio
//   jbus_ratio       in   cmp cycles per jbus cycle
//   dram_ratio       in   cmp cycles per dram cycle
//   start_sync       in   level: generate pulses while high
//   ctu_jbus_tx_sync out  global jbus tx sync pulse
//   ctu_jbus_rx_sync out  global jbus rx sync pulse
//   ctu_dram_tx_sync out  global dram tx sync pulse
//   ctu_dram_rx_sync out  global dram rx sync pulse
//   sync_locked      out  8 full jbus periods generated since start
//   cfg_err          out  sticky: illegal ratio, or cfg_ld outside idle
module ctu_sync_gen #(
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned JBUS_LEAD      = 3,
  parameter int unsigned DRAM_LEAD      = 2,
  parameter int unsigned JBUS_RATIO_DEF = 8,
  parameter int unsigned DRAM_RATIO_DEF = 4
) (
  input  logic             cmp_clk,
  input  logic             rst,
  input  logic             cfg_ld,
  input  logic [CNT_W-1:0] jbus_ratio,
  input  logic [CNT_W-1:0] dram_ratio,
  input  logic             start_sync,
  output logic             ctu_jbus_tx_sync,
  output logic             ctu_jbus_rx_sync,
  output logic             ctu_dram_tx_sync,
  output logic             ctu_dram_rx_sync,
  output logic             sync_locked,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] One      = CNT_W'(1);
  localparam logic [CNT_W-1:0] JMin     = CNT_W'(JBUS_LEAD + 1);
  localparam logic [CNT_W-1:0] DMin     = CNT_W'(DRAM_LEAD + 1);
  localparam logic [CNT_W-1:0] JLead    = CNT_W'(JBUS_LEAD);
  localparam logic [CNT_W-1:0] DLead    = CNT_W'(DRAM_LEAD);
  localparam logic [CNT_W-1:0] JRatioDf = CNT_W'(JBUS_RATIO_DEF);
  localparam logic [CNT_W-1:0] DRatioDf = CNT_W'(DRAM_RATIO_DEF);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] jratio_q, jratio_d, jtx_idx_q, jtx_idx_d, jrx_idx_q, jrx_idx_d;
  logic [CNT_W-1:0] dratio_q, dratio_d, dtx_idx_q, dtx_idx_d, drx_idx_q, drx_idx_d;
  logic [CNT_W-1:0] jcnt_q, jcnt_d, dcnt_q, dcnt_d;
  logic             jdone_q, jdone_d, ddone_q, ddone_d;
  logic [2:0]       wrap_q, wrap_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             jtx_q, jtx_d, jrx_q, jrx_d, dtx_q, dtx_d, drx_q, drx_d;

  logic             cfg_ok;
  logic             draining;
  logic             jwrap;
  logic [CNT_W-1:0] jlast, dlast;

  // Upper bound 2^CNT_W-1 is implied by the field width.
  assign cfg_ok = (jbus_ratio >= JMin) && (dram_ratio >= DMin);
  assign jlast  = jratio_q - One;
  assign dlast  = dratio_q - One;
  // A domain that reaches its last count while draining stops there. This
  // includes the final RUN cycle, where start_sync has already dropped.
  assign draining = ((state_q == StRun) && !start_sync) || (state_q == StDrain);

  always_comb begin
    state_d   = state_q;
    jratio_d  = jratio_q;
    jtx_idx_d = jtx_idx_q;
    jrx_idx_d = jrx_idx_q;
    dratio_d  = dratio_q;
    dtx_idx_d = dtx_idx_q;
    drx_idx_d = drx_idx_q;
    jcnt_d    = jcnt_q;
    dcnt_d    = dcnt_q;
    jdone_d   = jdone_q;
    ddone_d   = ddone_q;
    wrap_d    = wrap_q;
    locked_d  = locked_q;
    err_d     = err_q;
    jwrap     = 1'b0;

    // Configuration
    if (cfg_ld) begin
      if ((state_q == StIdle) && cfg_ok) begin
        jratio_d  = jbus_ratio;
        jtx_idx_d = jbus_ratio - JLead - One;
        jrx_idx_d = jbus_ratio - JLead;
        dratio_d  = dram_ratio;
        dtx_idx_d = dram_ratio - DLead - One;
        drx_idx_d = dram_ratio - DLead;
      end else begin
        err_d = 1'b1;
      end
    end

    // Main FSM
    unique case (state_q)
      StIdle: begin
        if (start_sync) state_d = StRun;
      end
      StRun: begin
        if (!start_sync) state_d = StDrain;
      end
      StDrain: begin
        if (jdone_q && ddone_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Phase counters
    if (state_q == StIdle) begin
      jcnt_d  = '0;
      dcnt_d  = '0;
      jdone_d = 1'b0;
      ddone_d = 1'b0;
    end else begin
      if (jdone_q) begin
        jcnt_d = '0;
      end else if (jcnt_q == jlast) begin
        jcnt_d = '0;
        jwrap  = 1'b1;
        if (draining) jdone_d = 1'b1;
      end else begin
        jcnt_d = jcnt_q + One;
      end

      if (ddone_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == dlast) begin
        dcnt_d = '0;
        if (draining) ddone_d = 1'b1;
      end else begin
        dcnt_d = dcnt_q + One;
      end
    end

    // Lock tracking: the wrap counter saturates at 7, so the 8th wrap sets lock.
    if (state_d != StRun) begin
      wrap_d   = '0;
      locked_d = 1'b0;
    end else if ((state_q == StRun) && jwrap) begin
      if (wrap_q == 3'd7) locked_d = 1'b1;
      else                wrap_d   = wrap_q + 3'd1;
    end

    // The outputs are registered copies of the next-cycle count match.
    // A frozen domain sits at 0 and must stay quiet even when an index is 0.
    jtx_d = (state_d != StIdle) && !jdone_d && (jcnt_d == jtx_idx_d);
    jrx_d = (state_d != StIdle) && !jdone_d && (jcnt_d == jrx_idx_d);
    dtx_d = (state_d != StIdle) && !ddone_d && (dcnt_d == dtx_idx_d);
    drx_d = (state_d != StIdle) && !ddone_d && (dcnt_d == drx_idx_d);
  end

  always_ff @(posedge cmp_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      jratio_q  <= JRatioDf;
      jtx_idx_q <= JRatioDf - JLead - One;
      jrx_idx_q <= JRatioDf - JLead;
      dratio_q  <= DRatioDf;
      dtx_idx_q <= DRatioDf - DLead - One;
      drx_idx_q <= DRatioDf - DLead;
      jcnt_q    <= '0;
      dcnt_q    <= '0;
      jdone_q   <= 1'b0;
      ddone_q   <= 1'b0;
      wrap_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      jtx_q     <= 1'b0;
      jrx_q     <= 1'b0;
      dtx_q     <= 1'b0;
      drx_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      jratio_q  <= jratio_d;
      jtx_idx_q <= jtx_idx_d;
      jrx_idx_q <= jrx_idx_d;
      dratio_q  <= dratio_d;
      dtx_idx_q <= dtx_idx_d;
      drx_idx_q <= drx_idx_d;
      jcnt_q    <= jcnt_d;
      dcnt_q    <= dcnt_d;
      jdone_q   <= jdone_d;
      ddone_q   <= ddone_d;
      wrap_q    <= wrap_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      jtx_q     <= jtx_d;
      jrx_q     <= jrx_d;
      dtx_q     <= dtx_d;
      drx_q     <= drx_d;
    end
  end

  assign ctu_jbus_tx_sync = jtx_q;
  assign ctu_jbus_rx_sync = jrx_q;
  assign ctu_dram_tx_sync = dtx_q;
  assign ctu_dram_rx_sync = drx_q;
  assign sync_locked      = locked_q;
  assign cfg_err          = err_q;

endmodule

// File: tb/tb_ctu_sync_gen.sv
// Directed bench for ctu_sync_gen. The pulse outputs are captured cycle by
// cycle into bit vectors, where bit i holds RUN cycle t(i+1). Each vector is
// then compared against a hand-computed pattern.
module tb_ctu_sync_gen;

  logic       cmp_clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_ld = 1'b0;
  logic [4:0] jbus_ratio = 5'd0;
  logic [4:0] dram_ratio = 5'd0;
  logic       start_sync = 1'b0;
  logic       ctu_jbus_tx_sync, ctu_jbus_rx_sync, ctu_dram_tx_sync, ctu_dram_rx_sync;
  logic       sync_locked, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] jtx_v, jrx_v, dtx_v, drx_v;

  ctu_sync_gen dut (
    .cmp_clk          (cmp_clk),
    .rst              (rst),
    .cfg_ld           (cfg_ld),
    .jbus_ratio       (jbus_ratio),
    .dram_ratio       (dram_ratio),
    .start_sync       (start_sync),
    .ctu_jbus_tx_sync (ctu_jbus_tx_sync),
    .ctu_jbus_rx_sync (ctu_jbus_rx_sync),
    .ctu_dram_tx_sync (ctu_dram_tx_sync),
    .ctu_dram_rx_sync (ctu_dram_rx_sync),
    .sync_locked      (sync_locked),
    .cfg_err          (cfg_err)
  );

  always #5 cmp_clk = ~cmp_clk;

  task automatic step();
    @(posedge cmp_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step n cycles and record the pulses. At index drop_at, start_sync goes low
  // after sampling (-1 means never).
  task automatic capture(input int n, input int drop_at);
    jtx_v = '0;
    jrx_v = '0;
    dtx_v = '0;
    drx_v = '0;
    for (int i = 0; i < n; i++) begin
      step();
      jtx_v[i] = ctu_jbus_tx_sync;
      jrx_v[i] = ctu_jbus_rx_sync;
      dtx_v[i] = ctu_dram_tx_sync;
      drx_v[i] = ctu_dram_rx_sync;
      if (i == drop_at) start_sync = 1'b0;
    end
  endtask

  task automatic load(input logic [4:0] j, input logic [4:0] d);
    cfg_ld     = 1'b1;
    jbus_ratio = j;
    dram_ratio = d;
    step();
    cfg_ld = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    rst = 1'b0;
    chk("rst_jtx", 64'(ctu_jbus_tx_sync), 64'd0);
    chk("rst_jrx", 64'(ctu_jbus_rx_sync), 64'd0);
    chk("rst_dtx", 64'(ctu_dram_tx_sync), 64'd0);
    chk("rst_drx", 64'(ctu_dram_rx_sync), 64'd0);
    chk("rst_lock", 64'(sync_locked), 64'd0);
    chk("rst_err", 64'(cfg_err), 64'd0);
    step();
    chk("idle_jtx", 64'(ctu_jbus_tx_sync), 64'd0);

    // Default ratios 8/4: jtx t5,t13; jrx t6,t14; dtx t2,6,10,14; drx t3,7,11,15
    start_sync = 1'b1;
    capture(16, -1);
    chk("def_jtx", jtx_v, 64'h1010);
    chk("def_jrx", jrx_v, 64'h2020);
    chk("def_dtx", dtx_v, 64'h2222);
    chk("def_drx", drx_v, 64'h4444);
    chk("lock_t16", 64'(sync_locked), 64'd0);

    // Lock rises at t65 (8th jbus wrap) and clears the cycle after start drops
    repeat (48) step();
    chk("lock_t64", 64'(sync_locked), 64'd0);
    step();
    chk("lock_t65", 64'(sync_locked), 64'd1);
    repeat (5) step();
    chk("lock_t70", 64'(sync_locked), 64'd1);
    start_sync = 1'b0;
    step();
    chk("lock_drop", 64'(sync_locked), 64'd0);
    repeat (20) step();

    // Drain: start drops during t3 (jcnt=2). The jbus period completes, while
    // dram ends at its t4 wrap. No pulses follow.
    start_sync = 1'b1;
    capture(16, 2);
    chk("drn_jtx", jtx_v, 64'h0010);
    chk("drn_jrx", jrx_v, 64'h0020);
    chk("drn_dtx", dtx_v, 64'h0002);
    chk("drn_drx", drx_v, 64'h0004);
    repeat (10) step();

    // Config 5/3: jtx idx1, jrx idx2, dtx idx0, drx idx1
    load(5'd5, 5'd3);
    chk("cfg_ok_err", 64'(cfg_err), 64'd0);
    start_sync = 1'b1;
    capture(16, -1);
    chk("c53_jtx", jtx_v, 64'h0842);
    chk("c53_jrx", jrx_v, 64'h1084);
    chk("c53_dtx", dtx_v, 64'h9249);
    chk("c53_drx", drx_v, 64'h2492);
    load(5'd9, 5'd4);
    chk("cfg_run_err", 64'(cfg_err), 64'd1);
    start_sync = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_rst", 64'(cfg_err), 64'd0);
    step();

    // jbus=3 is below the minimum of 4, so the load is ignored and the defaults remain
    load(5'd3, 5'd4);
    chk("cfg_bad_err", 64'(cfg_err), 64'd1);
    start_sync = 1'b1;
    capture(16, -1);
    chk("bad_jtx", jtx_v, 64'h1010);
    chk("bad_dtx", dtx_v, 64'h2222);
    start_sync = 1'b0;
    repeat (20) step();

    // Boundary: jbus=31 -> tx idx27, rx idx28, wraps at 30 (period 31)
    load(5'd31, 5'd4);
    chk("err_sticky", 64'(cfg_err), 64'd1);
    start_sync = 1'b1;
    capture(64, -1);
    chk("b31_jtx", jtx_v, 64'h0400_0000_0800_0000);
    chk("b31_jrx", jrx_v, 64'h0800_0000_1000_0000);

    // Reset mid-RUN in t89; t90 would otherwise carry jtx and dtx pulses
    repeat (25) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_jtx", 64'(ctu_jbus_tx_sync), 64'd0);
    chk("mrst_dtx", 64'(ctu_dram_tx_sync), 64'd0);
    chk("mrst_err", 64'(cfg_err), 64'd0);
    capture(16, -1);
    chk("mrst_def_jtx", jtx_v, 64'h1010);
    chk("mrst_def_dtx", dtx_v, 64'h2222);
    chk("mrst_def_drx", drx_v, 64'h4444);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
